// File: rtl/clause_unit_bt_if.sv
// ---------------------------------------------------------------------------
// clause_unit_bt_if
//   Bundles the clause-load, assignment-broadcast, backtrack and
//   implication-handshake signals of one clause_unit_bt instance.
//
//   master : driver side (clause array controller / arbiter / testbench)
//   slave  : the clause unit itself
//
//   Load bus       : update_clause_i, clause_id_to_set_i,
//                    set_variable_id_i, set_variable_polarity_i
//   Broadcast bus  : update_assignment_i, decision_variable_id_i,
//                    decision_assignment_i, decision_level_i
//   Backtrack      : backtrack_i, backtrack_level_i
//   Status         : clause_SAT_o, conflict_o, unit_o
//   Implication    : impl_valid_o, impl_ready_i, implication_variable_id_o,
//                    implication_assignment_o, implication_level_o
// ---------------------------------------------------------------------------
interface clause_unit_bt_if #(
    parameter int MAX_VARIABLE_ID       = 15,
    parameter int VARIABLE_ENCODING_LEN = $clog2(MAX_VARIABLE_ID + 1),
    parameter int MAX_CLAUSE_SIZE       = 4,
    parameter int MAX_LEVEL             = 15,
    parameter int LEVEL_LEN             = $clog2(MAX_LEVEL + 1),
    parameter int MAX_CLAUSE            = 16,
    parameter int CLAUSE_ID_LEN         = $clog2(MAX_CLAUSE)
);
    logic                                             update_clause_i;
    logic [CLAUSE_ID_LEN-1:0]                         clause_id_to_set_i;
    logic [MAX_CLAUSE_SIZE*VARIABLE_ENCODING_LEN-1:0] set_variable_id_i;
    logic [MAX_CLAUSE_SIZE-1:0]                       set_variable_polarity_i;
    logic                                             update_assignment_i;
    logic [VARIABLE_ENCODING_LEN-1:0]                 decision_variable_id_i;
    logic                                             decision_assignment_i;
    logic [LEVEL_LEN-1:0]                             decision_level_i;
    logic                                             backtrack_i;
    logic [LEVEL_LEN-1:0]                             backtrack_level_i;
    logic                                             clause_SAT_o;
    logic                                             conflict_o;
    logic                                             unit_o;
    logic                                             impl_valid_o;
    logic                                             impl_ready_i;
    logic [VARIABLE_ENCODING_LEN-1:0]                 implication_variable_id_o;
    logic                                             implication_assignment_o;
    logic [LEVEL_LEN-1:0]                             implication_level_o;

    modport master (
        output update_clause_i, clause_id_to_set_i, set_variable_id_i,
               set_variable_polarity_i, update_assignment_i,
               decision_variable_id_i, decision_assignment_i,
               decision_level_i, backtrack_i, backtrack_level_i, impl_ready_i,
        input  clause_SAT_o, conflict_o, unit_o, impl_valid_o,
               implication_variable_id_o, implication_assignment_o,
               implication_level_o
    );

    modport slave (
        input  update_clause_i, clause_id_to_set_i, set_variable_id_i,
               set_variable_polarity_i, update_assignment_i,
               decision_variable_id_i, decision_assignment_i,
               decision_level_i, backtrack_i, backtrack_level_i, impl_ready_i,
        output clause_SAT_o, conflict_o, unit_o, impl_valid_o,
               implication_variable_id_o, implication_assignment_o,
               implication_level_o
    );
endinterface

// File: rtl/clause_unit_bt.sv
// ---------------------------------------------------------------------------
// clause_unit_bt
//   Single-clause evaluator for the BCP accelerator. Holds up to
//   MAX_CLAUSE_SIZE literals, tracks per-literal assignment and decision
//   level, supports backtracking to a target level and offers unit
//   implications over a valid/ready handshake.
//
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   bus     : clause_unit_bt_if.slave (load, broadcast, backtrack,
//             registered status and implication handshake)
// ---------------------------------------------------------------------------
module clause_unit_bt #(
    parameter int MAX_VARIABLE_ID       = 15,
    parameter int VARIABLE_ENCODING_LEN = $clog2(MAX_VARIABLE_ID + 1),
    parameter int MAX_CLAUSE_SIZE       = 4,
    parameter int MAX_LEVEL             = 15,
    parameter int LEVEL_LEN             = $clog2(MAX_LEVEL + 1),
    parameter int MAX_CLAUSE            = 16,
    parameter int CLAUSE_ID             = 0,
    parameter int CLAUSE_ID_LEN         = $clog2(MAX_CLAUSE)
) (
    input logic             clk_i,
    input logic             rst_ni,
    clause_unit_bt_if.slave bus
);
    localparam int N  = MAX_CLAUSE_SIZE;
    localparam int VW = VARIABLE_ENCODING_LEN;
    localparam int LW = LEVEL_LEN;
    localparam logic [CLAUSE_ID_LEN-1:0] OWN_ID = CLAUSE_ID_LEN'(CLAUSE_ID);

    typedef enum logic [1:0] {
        IMPL_IDLE,
        IMPL_PEND,
        IMPL_DONE
    } implState_e;

    // Clause contents and per-slot assignment state
    logic          inUse_q,   inUse_d;
    logic [VW-1:0] slotId_q  [N];
    logic [VW-1:0] slotId_d  [N];
    logic [LW-1:0] slotLvl_q [N];
    logic [LW-1:0] slotLvl_d [N];
    logic [N-1:0]  slotPol_q, slotPol_d;
    logic [N-1:0]  slotAsg_q, slotAsg_d;
    logic [N-1:0]  slotVal_q, slotVal_d;

    // Status of the next state, registered into the outputs
    logic          clauseSat_d, conflict_d, unit_d;
    logic          clauseSat_q, conflict_q, unit_q;
    logic [VW-1:0] candId;
    logic          candVal;
    logic [LW-1:0] candLvl;

    // Implication FSM and its registered outputs
    implState_e    implState_q;
    logic          implValid_q;
    logic [VW-1:0] implId_q;
    logic          implVal_q;
    logic [LW-1:0] implLvl_q;

    logic loadHit;
    assign loadHit = bus.update_clause_i && (bus.clause_id_to_set_i == OWN_ID);

    // Next clause state. Load wins over backtrack, backtrack wins over
    // assignment; the losing event of the same cycle is dropped.
    always_comb begin
        inUse_d   = inUse_q;
        slotId_d  = slotId_q;
        slotLvl_d = slotLvl_q;
        slotPol_d = slotPol_q;
        slotAsg_d = slotAsg_q;
        slotVal_d = slotVal_q;
        if (loadHit) begin
            inUse_d = 1'b0;
            for (int k = 0; k < N; k++) begin
                slotId_d[k]  = bus.set_variable_id_i[k*VW +: VW];
                slotPol_d[k] = bus.set_variable_polarity_i[k];
                slotAsg_d[k] = 1'b0;
                slotVal_d[k] = 1'b0;
                slotLvl_d[k] = '0;
                if (bus.set_variable_id_i[k*VW +: VW] != '0) begin
                    inUse_d = 1'b1;
                end
            end
        end else if (bus.backtrack_i) begin
            for (int k = 0; k < N; k++) begin
                if (slotAsg_q[k] && (slotLvl_q[k] > bus.backtrack_level_i)) begin
                    slotAsg_d[k] = 1'b0;
                    slotVal_d[k] = 1'b0;
                    slotLvl_d[k] = '0;
                end
            end
        end else if (bus.update_assignment_i) begin
            // Duplicate ids in one clause all pick up the same broadcast.
            for (int k = 0; k < N; k++) begin
                if ((slotId_q[k] != '0) && !slotAsg_q[k] &&
                    (slotId_q[k] == bus.decision_variable_id_i)) begin
                    slotAsg_d[k] = 1'b1;
                    slotVal_d[k] = bus.decision_assignment_i;
                    slotLvl_d[k] = bus.decision_level_i;
                end
            end
        end
    end

    // Evaluate the next state so status lands one cycle after the strobe.
    // The unit candidate is the single free used slot; its level is the
    // deepest level among the assigned used slots.
    always_comb begin
        logic anyFree;
        logic multiFree;
        logic anyTrue;
        anyFree   = 1'b0;
        multiFree = 1'b0;
        anyTrue   = 1'b0;
        candId    = '0;
        candVal   = 1'b0;
        candLvl   = '0;
        for (int k = 0; k < N; k++) begin
            if (slotId_d[k] != '0) begin
                if (slotAsg_d[k]) begin
                    if (slotVal_d[k] == slotPol_d[k]) begin
                        anyTrue = 1'b1;
                    end
                    if (slotLvl_d[k] > candLvl) begin
                        candLvl = slotLvl_d[k];
                    end
                end else begin
                    if (anyFree) begin
                        multiFree = 1'b1;
                    end
                    anyFree = 1'b1;
                    candId  = slotId_d[k];
                    candVal = slotPol_d[k];
                end
            end
        end
        clauseSat_d = anyTrue || !inUse_d;
        conflict_d  = !clauseSat_d && !anyFree;
        unit_d      = !clauseSat_d && anyFree && !multiFree;
    end

    // Clause storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inUse_q   <= 1'b0;
            slotPol_q <= '0;
            slotAsg_q <= '0;
            slotVal_q <= '0;
            for (int k = 0; k < N; k++) begin
                slotId_q[k]  <= '0;
                slotLvl_q[k] <= '0;
            end
        end else begin
            inUse_q   <= inUse_d;
            slotId_q  <= slotId_d;
            slotLvl_q <= slotLvl_d;
            slotPol_q <= slotPol_d;
            slotAsg_q <= slotAsg_d;
            slotVal_q <= slotVal_d;
        end
    end

    // Status registers and implication FSM. An offer stays frozen while
    // PEND; if the clause stops being unit before acceptance it is
    // retracted. After acceptance DONE blocks re-offers until unit falls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clauseSat_q <= 1'b1;
            conflict_q  <= 1'b0;
            unit_q      <= 1'b0;
            implState_q <= IMPL_IDLE;
            implValid_q <= 1'b0;
            implId_q    <= '0;
            implVal_q   <= 1'b0;
            implLvl_q   <= '0;
        end else begin
            clauseSat_q <= clauseSat_d;
            conflict_q  <= conflict_d;
            unit_q      <= unit_d;
            if (loadHit) begin
                implState_q <= IMPL_IDLE;
                implValid_q <= 1'b0;
                implId_q    <= '0;
                implVal_q   <= 1'b0;
                implLvl_q   <= '0;
            end else begin
                case (implState_q)
                    IMPL_IDLE: begin
                        if (unit_d) begin
                            implState_q <= IMPL_PEND;
                            implValid_q <= 1'b1;
                            implId_q    <= candId;
                            implVal_q   <= candVal;
                            implLvl_q   <= candLvl;
                        end
                    end
                    IMPL_PEND: begin
                        if (bus.impl_ready_i || !unit_d) begin
                            implState_q <= (bus.impl_ready_i && unit_d) ? IMPL_DONE : IMPL_IDLE;
                            implValid_q <= 1'b0;
                            implId_q    <= '0;
                            implVal_q   <= 1'b0;
                            implLvl_q   <= '0;
                        end
                    end
                    IMPL_DONE: begin
                        if (!unit_d) begin
                            implState_q <= IMPL_IDLE;
                        end
                    end
                    default: begin
                        implState_q <= IMPL_IDLE;
                        implValid_q <= 1'b0;
                        implId_q    <= '0;
                        implVal_q   <= 1'b0;
                        implLvl_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.clause_SAT_o              = clauseSat_q;
    assign bus.conflict_o                = conflict_q;
    assign bus.unit_o                    = unit_q;
    assign bus.impl_valid_o              = implValid_q;
    assign bus.implication_variable_id_o = implId_q;
    assign bus.implication_assignment_o  = implVal_q;
    assign bus.implication_level_o       = implLvl_q;

endmodule

// File: tb/tb_clause_unit_bt.sv
// ---------------------------------------------------------------------------
// tb_clause_unit_bt
//   Scoreboard bench for clause_unit_bt. Stimulus updates a literal-level
//   reference model and queues the expected status and implications; an
//   independent monitor compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_clause_unit_bt;
    localparam int MAXV = 15;
    localparam int NS   = 4;
    localparam int MAXL = 15;
    localparam int MAXC = 16;
    localparam int CID  = 5;
    localparam int VW   = $clog2(MAXV + 1);
    localparam int LW   = $clog2(MAXL + 1);
    localparam int CLW  = $clog2(MAXC);

    typedef struct { int sat; int conflict; int unit; int valid; } status_t;
    typedef struct { int id; int val; int lvl; } impl_t;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    clause_unit_bt_if #(
        .MAX_VARIABLE_ID(MAXV), .MAX_CLAUSE_SIZE(NS),
        .MAX_LEVEL(MAXL), .MAX_CLAUSE(MAXC)
    ) bus ();

    clause_unit_bt #(
        .MAX_VARIABLE_ID(MAXV), .MAX_CLAUSE_SIZE(NS), .MAX_LEVEL(MAXL),
        .MAX_CLAUSE(MAXC), .CLAUSE_ID(CID)
    ) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus)
    );

    int      checks = 0;
    int      errors = 0;
    status_t statusQ[$];
    impl_t   implQ[$];
    logic    monitorOn = 1'b0;

    // Reference model: the clause as a literal list with per-literal state
    int mdlId  [NS];
    int mdlPol [NS];
    int mdlAsg [NS];
    int mdlVal [NS];
    int mdlLvl [NS];
    int mdlInUse;
    int mdlValid;
    int mdlAcked;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < NS; k++) begin
            mdlId[k]  = 0;
            mdlPol[k] = 0;
            mdlAsg[k] = 0;
            mdlVal[k] = 0;
            mdlLvl[k] = 0;
        end
        mdlInUse = 0;
        mdlValid = 0;
        mdlAcked = 0;
    endtask

    // Apply one clock's worth of events to the model, then derive the
    // expected status from literal counts and the offer/acceptance rules.
    task automatic modelStep(input bit ldHit, input logic [NS*VW-1:0] ids,
                             input logic [NS-1:0] pols, input bit bt, input int btl,
                             input bit asg, input int v, input int a, input int l,
                             input bit rdy);
        int oldValid;
        int numTrue;
        int numFree;
        int maxLvl;
        int freeId;
        int freePol;
        int sat;
        int unit;
        int conflict;
        oldValid = mdlValid;
        if (ldHit) begin
            mdlInUse = 0;
            for (int k = 0; k < NS; k++) begin
                mdlId[k]  = int'(ids[k*VW +: VW]);
                mdlPol[k] = int'(pols[k]);
                mdlAsg[k] = 0;
                mdlVal[k] = 0;
                mdlLvl[k] = 0;
                if (mdlId[k] != 0) mdlInUse = 1;
            end
        end else if (bt) begin
            for (int k = 0; k < NS; k++)
                if (mdlAsg[k] == 1 && mdlLvl[k] > btl) mdlAsg[k] = 0;
        end else if (asg) begin
            for (int k = 0; k < NS; k++)
                if (mdlId[k] != 0 && mdlAsg[k] == 0 && mdlId[k] == v) begin
                    mdlAsg[k] = 1;
                    mdlVal[k] = a;
                    mdlLvl[k] = l;
                end
        end
        numTrue = 0;
        numFree = 0;
        maxLvl  = 0;
        freeId  = 0;
        freePol = 0;
        for (int k = 0; k < NS; k++) begin
            if (mdlId[k] == 0) continue;
            if (mdlAsg[k] == 0) begin
                numFree++;
                freeId  = mdlId[k];
                freePol = mdlPol[k];
            end else begin
                if (mdlVal[k] == mdlPol[k]) numTrue++;
                if (mdlLvl[k] > maxLvl) maxLvl = mdlLvl[k];
            end
        end
        sat      = (mdlInUse == 0 || numTrue > 0) ? 1 : 0;
        unit     = (sat == 0 && numFree == 1) ? 1 : 0;
        conflict = (sat == 0 && numFree == 0) ? 1 : 0;
        if (ldHit) begin
            mdlValid = 0;
            mdlAcked = 0;
        end else if (oldValid == 1 && rdy) begin
            mdlValid = 0;
            mdlAcked = unit;
        end else if (unit == 0) begin
            mdlValid = 0;
            mdlAcked = 0;
        end else begin
            mdlValid = (mdlAcked == 0) ? 1 : 0;
        end
        if (mdlValid == 1 && oldValid == 0) implQ.push_back('{freeId, freePol, maxLvl});
        statusQ.push_back('{sat, conflict, unit, mdlValid});
    endtask

    task automatic driveIdle();
        bus.update_clause_i         = 1'b0;
        bus.clause_id_to_set_i      = '0;
        bus.set_variable_id_i       = '0;
        bus.set_variable_polarity_i = '0;
        bus.update_assignment_i     = 1'b0;
        bus.decision_variable_id_i  = '0;
        bus.decision_assignment_i   = 1'b0;
        bus.decision_level_i        = '0;
        bus.backtrack_i             = 1'b0;
        bus.backtrack_level_i       = '0;
        bus.impl_ready_i            = 1'b0;
    endtask

    task automatic applyStimulus(input bit ld, input int cid, input logic [NS*VW-1:0] ids,
                                 input logic [NS-1:0] pols, input bit bt, input int btl,
                                 input bit asg, input int v, input int a, input int l,
                                 input bit rdy);
        @(negedge clk);
        bus.update_clause_i         = ld;
        bus.clause_id_to_set_i      = CLW'(cid);
        bus.set_variable_id_i       = ids;
        bus.set_variable_polarity_i = pols;
        bus.backtrack_i             = bt;
        bus.backtrack_level_i       = LW'(btl);
        bus.update_assignment_i     = asg;
        bus.decision_variable_id_i  = VW'(v);
        bus.decision_assignment_i   = 1'(a);
        bus.decision_level_i        = LW'(l);
        bus.impl_ready_i            = rdy;
        modelStep(ld && (cid == CID), ids, pols, bt, btl, asg, v, a, l, rdy);
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 0, '0, '0, 1'b0, 0, 1'b0, 0, 0, 0, rdy);
    endtask

    task automatic doLoad(input int cid, input logic [NS*VW-1:0] ids,
                          input logic [NS-1:0] pols, input bit rdy);
        applyStimulus(1'b1, cid, ids, pols, 1'b0, 0, 1'b0, 0, 0, 0, rdy);
    endtask

    task automatic doAssign(input int v, input int a, input int l, input bit rdy);
        applyStimulus(1'b0, 0, '0, '0, 1'b0, 0, 1'b1, v, a, l, rdy);
    endtask

    task automatic doBacktrack(input int l, input bit rdy);
        applyStimulus(1'b0, 0, '0, '0, 1'b1, l, 1'b0, 0, 0, 0, rdy);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " clause_SAT_o"}, int'(bus.clause_SAT_o), 1);
        checkOutput({tag, " conflict_o"}, int'(bus.conflict_o), 0);
        checkOutput({tag, " unit_o"}, int'(bus.unit_o), 0);
        checkOutput({tag, " impl_valid_o"}, int'(bus.impl_valid_o), 0);
        checkOutput({tag, " impl id"}, int'(bus.implication_variable_id_o), 0);
        checkOutput({tag, " impl value"}, int'(bus.implication_assignment_o), 0);
        checkOutput({tag, " impl level"}, int'(bus.implication_level_o), 0);
    endtask

    // Asynchronous reset in the middle of the run; valid must drop at once.
    task automatic resetMidRun();
        @(posedge clk);
        #3;
        monitorOn = 1'b0;
        checkOutput("valid before reset", int'(bus.impl_valid_o), mdlValid);
        rstN = 1'b0;
        #1;
        checkResetOutputs("mid-run reset");
        statusQ.delete();
        implQ.delete();
        modelReset();
        driveIdle();
        @(posedge clk);
        #3;
        rstN      = 1'b1;
        monitorOn = 1'b1;
    endtask

    // Monitor: one status entry per clock, one implication entry per new offer
    always @(posedge clk) begin
        status_t st;
        impl_t   cur;
        logic    prevValid;
        #2;
        if (monitorOn) begin
            if (statusQ.size() == 0) begin
                checkOutput("status queue underflow", 0, 1);
            end else begin
                st = statusQ.pop_front();
                checkOutput("clause_SAT_o", int'(bus.clause_SAT_o), st.sat);
                checkOutput("conflict_o", int'(bus.conflict_o), st.conflict);
                checkOutput("unit_o", int'(bus.unit_o), st.unit);
                checkOutput("impl_valid_o", int'(bus.impl_valid_o), st.valid);
            end
            checkOutput("conflict and unit exclusive", int'(bus.conflict_o & bus.unit_o), 0);
            if (bus.impl_valid_o && !prevValid) begin
                if (implQ.size() == 0) checkOutput("unexpected implication", 1, 0);
                else cur = implQ.pop_front();
            end
            if (bus.impl_valid_o) begin
                checkOutput("impl variable", int'(bus.implication_variable_id_o), cur.id);
                checkOutput("impl value", int'(bus.implication_assignment_o), cur.val);
                checkOutput("impl level", int'(bus.implication_level_o), cur.lvl);
            end else begin
                checkOutput("impl variable idle", int'(bus.implication_variable_id_o), 0);
            end
            prevValid = bus.impl_valid_o;
        end else begin
            prevValid = 1'b0;
        end
    end

    initial begin
        rstN = 1'b0;
        driveIdle();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        #3;
        rstN      = 1'b1;
        monitorOn = 1'b1;

        $display("[TB] directed sequence");
        doLoad(CID, 16'h0321, 4'b0101, 1'b0);
        doAssign(1, 0, 1, 1'b0);
        doAssign(2, 1, 2, 1'b0);
        repeat (5) idle(1'b0);
        idle(1'b1);
        repeat (3) idle(1'b1);
        doAssign(3, 0, 3, 1'b1);
        doBacktrack(2, 1'b0);
        idle(1'b0);
        idle(1'b1);
        doBacktrack(1, 1'b1);
        doAssign(2, 0, 2, 1'b1);
        doBacktrack(0, 1'b1);
        doAssign(1, 0, 1, 1'b1);
        applyStimulus(1'b0, 0, '0, '0, 1'b1, 0, 1'b1, 2, 1, 2, 1'b1);
        doLoad(3, 16'h0987, 4'b1111, 1'b1);
        doAssign(1, 0, 4, 1'b1);
        doAssign(2, 1, 5, 1'b1);
        doLoad(CID, 16'h0000, 4'b1010, 1'b1);
        idle(1'b1);
        doAssign(0, 1, 3, 1'b1);
        doLoad(CID, 16'h0007, 4'b0001, 1'b0);
        repeat (3) idle(1'b0);
        resetMidRun();

        $display("[TB] random sequence");
        for (int c = 0; c < 600; c++) begin
            int               r;
            bit               rdy;
            logic [NS*VW-1:0] rIds;
            r   = int'($urandom_range(0, 99));
            rdy = ($urandom_range(0, 2) != 0);
            if (r < 7) begin
                for (int k = 0; k < NS; k++) rIds[k*VW +: VW] = VW'($urandom_range(0, 5));
                doLoad(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXC - 1)) : CID,
                       rIds, NS'($urandom()), rdy);
            end else if (r < 22) begin
                applyStimulus(1'b0, 0, '0, '0, 1'b1, int'($urandom_range(0, MAXL)),
                              ($urandom_range(0, 3) == 0), int'($urandom_range(1, 6)),
                              int'($urandom_range(0, 1)), int'($urandom_range(1, MAXL)), rdy);
            end else if (r < 75) begin
                doAssign(int'($urandom_range(1, 6)), int'($urandom_range(0, 1)),
                         int'($urandom_range(1, MAXL)), rdy);
            end else begin
                idle(rdy);
            end
        end

        repeat (4) idle(1'b1);
        @(posedge clk);
        #3;
        checkOutput("implication queue drained", implQ.size(), 0);
        checkOutput("status queue drained", statusQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
